ps2_kbd_ctrl: RTL and testbench
===============================

Name: ps2_kbd_ctrl

Overview:
PS/2 keyboard receive controller. It samples raw ps2_clk/ps2_dat, assembles and checks 11-bit frames, and runs a scan-code state machine that folds E0 (extended) and F0 (break) prefixes into single key events. Events are queued in a small FIFO behind a valid/ready interface. It sits between the keyboard pins and any key consumer (display, game logic), replacing ad-hoc byte capture.

Parameters:
TIMEOUT_CYC, 100000, idle clk cycles mid-frame before the partial frame is discarded (2 ms at 50 MHz)
FIFO_DEPTH, 4, event queue entries (power of 2, at least 2)

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous, active-low
ps2_clk  in  1  raw PS/2 clock from pin
ps2_dat  in  1  raw PS/2 data from pin
evt_valid  out  1  head event available
evt_ready  in  1  consumer accepts head event this cycle
evt_code  out  8  scan code of head event
evt_ext  out  1  head event was E0-prefixed
evt_break  out  1  head event is a key release (F0-prefixed)
frame_err  out  1  1-cycle pulse: bad start/parity/stop or timeout
evt_ovf  out  1  1-cycle pulse: event dropped, FIFO full

Behaviour:
- Reset: outputs 0; FSM IDLE; FIFO empty; bit counter 0; timeout counter 0. Pin synchroniser flops reset to 1 (idle bus) so no false edge occurs after reset.
- Sync: 2-flop synchroniser on ps2_clk and ps2_dat. fall = prev_sync & ~cur_sync; data is sampled from the synchronised ps2_dat in the fall cycle.
- Frame: bit counter 0..10, LSB first: start, d0..d7, parity, stop. On the fall with counter 10:
  - Good frame (start==0, odd parity over d0..d7 plus parity bit ==1, stop==1): byte_valid pulses next cycle with the byte.
  - Bad frame: frame_err pulses next cycle; no byte.
  - Counter returns to 0 in either case.
- Timeout: while counter != 0, count clk cycles since the last fall. On reaching TIMEOUT_CYC-1: counter to 0, partial data discarded, frame_err pulses. The timeout counter clears on every fall.
- Decoder FSM, acts only on byte_valid:
  - IDLE: E0->EXT; F0->BRK; 00 or FF->IDLE, no event; other->emit{code,ext=0,brk=0}, stay IDLE.
  - EXT: F0->EXT_BRK; E0->EXT; other->emit{ext=1,brk=0}, then IDLE.
  - BRK: E0->EXT_BRK; F0->BRK; other->emit{ext=0,brk=1}, then IDLE.
  - EXT_BRK: E0/F0 stay; other->emit{ext=1,brk=1}, then IDLE.
  - 00/FF in any state: no event, go to IDLE.
  - frame_err in any state forces IDLE (prefix discarded).
- FIFO: entries are {ext,brk,code}, 10 bits. Emit and push happen in the same cycle as byte_valid.
  - Push accepted if not full, or if full and a pop occurs the same cycle.
  - Otherwise the entry is dropped and evt_ovf pulses; FIFO contents are unchanged.
  - Pop when evt_valid & evt_ready. Pointers wrap modulo FIFO_DEPTH; count is clog2(FIFO_DEPTH)+1 bits.
- Output: evt_* show the head entry combinationally from the FIFO registers. evt_valid = (count != 0). evt_code/ext/break read 0 when empty.
- Latency: fall of stop bit in cycle N -> byte_valid N+1 -> FIFO write at end of N+1 -> evt_valid high in N+2 (if the FIFO was empty). Pin-to-fall adds 2-3 clk of synchroniser delay.
- Simultaneous events: push and pop in the same cycle leave count unchanged. frame_err and byte_valid are mutually exclusive by construction.
- Reset mid-frame or mid-prefix discards all state; no event is produced for that frame.

Decomposition:
- Package ps2_pkg: constants PS2_EXT=8'hE0, PS2_BRK=8'hF0, PS2_ERR0=8'h00, PS2_ERR1=8'hFF; decoder state enum IDLE/EXT/BRK/EXT_BRK; EVT_W=10.
- Sub-module ps2_frame_rx: synchroniser, edge detect, bit counter, shift register, parity/stop check, timeout. Outputs byte_valid, byte, frame_err.
- Decoder FSM and FIFO live in the top level.

Test Plan:
- Good frame 0x1C (parity 0), evt_ready=1 -> one event code=1C ext=0 brk=0, evt_valid high one cycle, no frame_err.
- Frames F0,1C -> exactly one event code=1C brk=1 ext=0; no event for F0.
- Frames E0,F0,75 -> one event code=75 ext=1 brk=1; then 1C -> code=1C ext=0 brk=0 (prefix cleared).
- Frame 0x1C with parity bit flipped -> frame_err pulse, no event. Next good 0x1C decodes normally. Repeat with stop=0 and start=1.
- Frame stops after 4 bits, bus idle > TIMEOUT_CYC -> single frame_err pulse, no event. Next good frame 0x32 -> code=32.
- evt_ready=0, send makes 15,1D,24,2D,2C -> FIFO holds four events, evt_ovf pulses once on 2C. Raise evt_ready -> 15,1D,24,2D delivered in order, then evt_valid=0.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared constants and types for the PS/2 keyboard receive path:
// prefix/error byte values, decoder states and the queued key-event format.
package ps2_pkg;

    localparam logic [7:0] PS2_EXT  = 8'hE0;
    localparam logic [7:0] PS2_BRK  = 8'hF0;
    localparam logic [7:0] PS2_ERR0 = 8'h00;
    localparam logic [7:0] PS2_ERR1 = 8'hFF;

    localparam int EVT_W = 10;

    typedef enum logic [1:0] {
        IDLE,
        EXT,
        BRK,
        EXT_BRK
    } dec_state_t;

    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } evt_t;

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: pin synchroniser, falling-edge detect, 11-bit frame
// assembly with start/parity/stop checks and a mid-frame idle timeout.
module ps2_frame_rx
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    output logic       byte_valid,
    output logic [7:0] rx_byte,
    output logic       frame_err
);

    localparam int TMO_W = $clog2(TIMEOUT_CYC);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

    logic [1:0]       clk_sync;
    logic [1:0]       dat_sync;
    logic             clk_prev;
    logic [3:0]       bit_cnt;
    logic [9:0]       shreg;
    logic [TMO_W-1:0] tmo_cnt;
    logic             fall;
    logic             frame_ok;

    assign fall = clk_prev & ~clk_sync[1];

    // After ten shifts: shreg[0]=start, shreg[8:1]=d0..d7, shreg[9]=parity.
    assign frame_ok = ~shreg[0] & (^shreg[9:1]) & dat_sync[1];

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_sync   <= 2'b11;
            dat_sync   <= 2'b11;
            clk_prev   <= 1'b1;
            bit_cnt    <= '0;
            shreg      <= '0;
            tmo_cnt    <= '0;
            byte_valid <= 1'b0;
            rx_byte    <= '0;
            frame_err  <= 1'b0;
        end else begin
            clk_sync   <= {clk_sync[0], ps2_clk};
            dat_sync   <= {dat_sync[0], ps2_dat};
            clk_prev   <= clk_sync[1];
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            if (fall) begin
                tmo_cnt <= '0;
                if (bit_cnt == 4'd10) begin
                    bit_cnt <= '0;
                    if (frame_ok) begin
                        byte_valid <= 1'b1;
                        rx_byte    <= shreg[8:1];
                    end else begin
                        frame_err  <= 1'b1;
                    end
                end else begin
                    shreg   <= {dat_sync[1], shreg[9:1]};
                    bit_cnt <= bit_cnt + 4'd1;
                end
            end else if (bit_cnt != 4'd0) begin
                // Keyboard went quiet mid-frame: drop the partial frame.
                if (tmo_cnt == TMO_LAST) begin
                    bit_cnt   <= '0;
                    tmo_cnt   <= '0;
                    frame_err <= 1'b1;
                end else begin
                    tmo_cnt <= tmo_cnt + TMO_W'(1);
                end
            end else begin
                tmo_cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/ps2_kbd_ctrl.sv
// PS/2 keyboard controller: folds E0/F0 prefixes into single key events and
// queues them in a small FIFO behind a valid/ready interface.
module ps2_kbd_ctrl
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYC = 100000,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    output logic       evt_valid,
    input  logic       evt_ready,
    output logic [7:0] evt_code,
    output logic       evt_ext,
    output logic       evt_break,
    output logic       frame_err,
    output logic       evt_ovf
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic       byte_valid;
    logic [7:0] rx_byte;

    ps2_frame_rx #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_frame_rx (
        .clk        (clk),
        .rst_n      (rst_n),
        .ps2_clk    (ps2_clk),
        .ps2_dat    (ps2_dat),
        .byte_valid (byte_valid),
        .rx_byte    (rx_byte),
        .frame_err  (frame_err)
    );

    dec_state_t state_q, state_d;
    logic       emit;
    evt_t       emit_evt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // NOTE: every always_comb output gets a default first so no path
    // leaves it unassigned and infers a latch.
    always_comb begin
        state_d = state_q;
        if (frame_err) begin
            state_d = IDLE;
        end else if (byte_valid) begin
            case (rx_byte)
                PS2_EXT: state_d = (state_q == BRK || state_q == EXT_BRK) ? EXT_BRK : EXT;
                PS2_BRK: state_d = (state_q == EXT || state_q == EXT_BRK) ? EXT_BRK : BRK;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        emit     = 1'b0;
        emit_evt = '0;
        if (byte_valid && !(rx_byte inside {PS2_EXT, PS2_BRK, PS2_ERR0, PS2_ERR1})) begin
            emit          = 1'b1;
            emit_evt.code = rx_byte;
            case (state_q)
                EXT:     emit_evt.ext = 1'b1;
                BRK:     emit_evt.brk = 1'b1;
                EXT_BRK: begin
                    emit_evt.ext = 1'b1;
                    emit_evt.brk = 1'b1;
                end
                default: ;
            endcase
        end
    end

    evt_t             mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count;
    logic             full, push, pop;

    assign full = (count == CNT_W'(FIFO_DEPTH));
    assign pop  = evt_valid & evt_ready;
    // A full FIFO still takes the new event when the head leaves this cycle.
    assign push = emit & (~full | pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            evt_ovf <= 1'b0;
        end else begin
            evt_ovf <= emit & ~push;
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: ;
            endcase
        end
    end

    // NOTE: the storage array has no reset; count gates every read, so
    // stale entries are never visible and the array maps to plain RAM.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= emit_evt;
    end

    evt_t head;
    assign head      = mem[rd_ptr];
    assign evt_valid = (count != '0);
    assign evt_code  = evt_valid ? head.code : 8'h00;
    assign evt_ext   = evt_valid & head.ext;
    assign evt_break = evt_valid & head.brk;

endmodule

// File: tb/tb_ps2_kbd_ctrl.sv
// Self-checking bench for ps2_kbd_ctrl: drives PS/2 frames at pin level and
// compares key events against a prefix-flag reference model via a scoreboard.
module tb_ps2_kbd_ctrl;

    localparam int TMO   = 1000;
    localparam int DEPTH = 4;
    localparam int HALF  = 8;

    localparam int K_GOOD  = 0;
    localparam int K_PAR   = 1;
    localparam int K_STOP  = 2;
    localparam int K_START = 3;
    localparam int K_TRUNC = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ps2_clk;
    logic       ps2_dat;
    logic       evt_valid;
    logic       evt_ready;
    logic [7:0] evt_code;
    logic       evt_ext;
    logic       evt_break;
    logic       frame_err;
    logic       evt_ovf;

    ps2_kbd_ctrl #(
        .TIMEOUT_CYC (TMO),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ps2_clk   (ps2_clk),
        .ps2_dat   (ps2_dat),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_code  (evt_code),
        .evt_ext   (evt_ext),
        .evt_break (evt_break),
        .frame_err (frame_err),
        .evt_ovf   (evt_ovf)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int errors   = 0;
    int err_exp  = 0;
    int err_seen = 0;
    int ovf_exp  = 0;
    int ovf_seen = 0;

    // Expected events, packed as {ext, brk, code}.
    logic [9:0] exp_q[$];
    logic [9:0] mon_e;
    bit         ext_f;
    bit         brk_f;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference decoder: pending prefixes are two flags; a plain byte
    // becomes an event carrying them, error bytes just clear them.
    task automatic model_byte(input logic [7:0] b);
        if (b == 8'h00 || b == 8'hFF) begin
            ext_f = 0;
            brk_f = 0;
        end else if (b == 8'hE0) begin
            ext_f = 1;
        end else if (b == 8'hF0) begin
            brk_f = 1;
        end else begin
            if (exp_q.size() >= DEPTH) ovf_exp++;
            else exp_q.push_back({ext_f, brk_f, b});
            ext_f = 0;
            brk_f = 0;
        end
    endtask

    task automatic ps2_bit(input logic b);
        ps2_dat = b;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input int kind);
        logic [10:0] bits;
        int          n;
        if (kind == K_GOOD) begin
            model_byte(b);
        end else begin
            err_exp++;
            ext_f = 0;
            brk_f = 0;
        end
        bits = {1'b1, ~^b, b, 1'b0};
        if (kind == K_PAR)   bits[9]  = ~bits[9];
        if (kind == K_STOP)  bits[10] = 1'b0;
        if (kind == K_START) bits[0]  = 1'b1;
        n = (kind == K_TRUNC) ? 4 : 11;
        for (int i = 0; i < n; i++) ps2_bit(bits[i]);
        ps2_dat = 1'b1;
        if (kind == K_TRUNC) repeat (TMO + 20) @(negedge clk);
        else                 repeat (3 * HALF) @(negedge clk);
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        repeat (4) @(negedge clk);
        check("drain_pending", exp_q.size(), 0);
    endtask

    // Scoreboard monitor: every accepted head event is compared in order.
    always @(negedge clk) begin
        if (rst_n) begin
            if (frame_err) err_seen++;
            if (evt_ovf)   ovf_seen++;
            if (evt_valid && evt_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_evt: got %h expected none", {evt_ext, evt_break, evt_code});
                end else begin
                    mon_e = exp_q.pop_front();
                    check("evt", {22'd0, evt_ext, evt_break, evt_code}, {22'd0, mon_e});
                end
            end
        end
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [7:0] b;
        int         kind;
        int         r;

        ps2_clk   = 1'b1;
        ps2_dat   = 1'b1;
        evt_ready = 1'b1;
        rst_n     = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        check("rst_evt_valid", evt_valid, 0);
        check("rst_evt_code",  evt_code,  0);
        check("rst_evt_ext",   evt_ext,   0);
        check("rst_evt_break", evt_break, 0);
        check("rst_frame_err", frame_err, 0);
        check("rst_evt_ovf",   evt_ovf,   0);

        // Make, break, extended break, then prefix cleared.
        send_frame(8'h1C, K_GOOD);
        send_frame(8'hF0, K_GOOD);
        send_frame(8'h1C, K_GOOD);
        send_frame(8'hE0, K_GOOD);
        send_frame(8'hF0, K_GOOD);
        send_frame(8'h75, K_GOOD);
        send_frame(8'h1C, K_GOOD);
        wait_drain();
        check("no_err_good", err_seen, 0);

        // Corrupt frames, each followed by a good one.
        send_frame(8'h1C, K_PAR);
        send_frame(8'h1C, K_GOOD);
        send_frame(8'h1C, K_STOP);
        send_frame(8'h1C, K_GOOD);
        send_frame(8'h1C, K_START);
        send_frame(8'h1C, K_GOOD);
        send_frame(8'hE0, K_GOOD);
        send_frame(8'h5A, K_TRUNC);
        send_frame(8'h32, K_GOOD);
        wait_drain();
        check("err_count_directed", err_seen, err_exp);

        // Reset in the middle of a frame that follows an E0 prefix.
        send_frame(8'hE0, K_GOOD);
        for (int i = 0; i < 3; i++) ps2_bit(1'b0);
        ps2_dat = 1'b1;
        rst_n   = 1'b0;
        ext_f   = 0;
        brk_f   = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        send_frame(8'h1C, K_GOOD);
        wait_drain();

        // Randomised byte stream with occasional corrupted frames.
        for (int i = 0; i < 150; i++) begin
            r = $urandom_range(0, 9);
            if (r < 2)       b = 8'hE0;
            else if (r == 2) b = 8'hF0;
            else if (r == 3) b = ($urandom_range(0, 1) != 0) ? 8'hFF : 8'h00;
            else             b = 8'($urandom_range(0, 255));
            kind = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 3)) : K_GOOD;
            send_frame(b, kind);
        end
        wait_drain();
        check("err_count_random", err_seen, err_exp);

        // Back-pressure: fifth event overflows a four-entry queue.
        @(posedge clk);
        #1 evt_ready = 1'b0;
        send_frame(8'h15, K_GOOD);
        send_frame(8'h1D, K_GOOD);
        send_frame(8'h24, K_GOOD);
        send_frame(8'h2D, K_GOOD);
        send_frame(8'h2C, K_GOOD);
        repeat (10) @(negedge clk);
        check("ovf_count", ovf_seen, 1);
        check("ovf_model", ovf_seen, ovf_exp);
        check("full_valid", evt_valid, 1);
        check("full_head", evt_code, 8'h15);
        @(posedge clk);
        #1 evt_ready = 1'b1;
        wait_drain();
        check("empty_valid", evt_valid, 0);
        check("empty_code",  {evt_ext, evt_break, evt_code}, 0);

        check("err_count_final", err_seen, err_exp);
        check("ovf_count_final", ovf_seen, ovf_exp);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
